wr_burst_feeder: RTL and testbench

Upstream feeder for the AXI write master. Buffers a streaming word source (camera/pattern generator) in an internal FWFT FIFO. Once a full burst is buffered, or on flush, it issues a write request: `wr_trig` with `wr_addr`/`wr_len`. It then supplies one word per `wr_data_en` pulse and advances a linear frame address that wraps at the end of the frame buffer.

---
 rtl/wr_burst_feeder.sv | 234 +++++++++++++++++++++++
 tb/tb_wr_burst_feeder.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_burst_feeder.sv
// Small first-word-fall-through FIFO used as the burst staging buffer.
// Latency: a word pushed at edge N is at the head and in the level from cycle N+1; head read is combinational.
// Backpressure: full is derived from registered pointers only; pushes while full and pops while empty are ignored.
module wr_burst_fifo #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // One extra pointer bit lets the difference span 0..DEPTH without a separate count register.
    assign level    = wr_ptr - rd_ptr;
    assign full     = (level == DEPTH_L);
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // Head word is only meaningful while not empty.
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Storage array carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    // Read/write pointers; reset empties the buffer and discards its contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// Stages a word stream and issues write-master bursts at a linear, wrapping frame address.
// Latency: wr_trig 2 cycles after the word completing a burst; next request no earlier than 3 cycles after wr_done.
// Backpressure: in_ready = !full from registered state; wr_data_en pops are honoured in every state.
module wr_burst_feeder #(
    parameter int ADDR_WIDTH  = 26,
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_AW     = 6,
    parameter int BURST_LEN   = 8,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_end,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  wr_trig,
    output logic [7:0]            wr_len,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_ready,
    input  logic                  wr_data_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_done,
    output logic [FIFO_AW:0]      fifo_level,
    output logic                  frame_done,
    output logic                  underflow_err
);

    localparam logic [FIFO_AW:0]    BURST_L   = (FIFO_AW + 1)'(BURST_LEN);
    localparam logic [7:0]          BURST_L8  = 8'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
    // End of the frame buffer, one bit wider than the address so the compare never overflows.
    localparam logic [ADDR_WIDTH:0] FRAME_END = (ADDR_WIDTH + 1)'(BASE_ADDR + FRAME_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BUSY,
        S_ADV
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  flush_pend;
    logic                  trig_cond;
    logic                  issue;
    logic                  adv;
    logic                  addr_wrap;
    logic [7:0]            len_sel;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   nxt_addr;

    wr_burst_fifo #(
        .DW (DATA_WIDTH),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (in_valid),
        .push_dat (in_data),
        .pop      (wr_data_en),
        .head_dat (wr_data),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign in_ready = !fifo_full;

    // A full burst is buffered, or a flush asks for whatever is present; both need the DDR up and the master idle.
    assign trig_cond = init_end && wr_ready &&
                       ((fifo_level >= BURST_L) || (flush_pend && !fifo_empty));

    // A flush burst carries the current level, which is below BURST_LEN by construction of trig_cond.
    assign len_sel = (fifo_level >= BURST_L) ? BURST_L8 : 8'(fifo_level);

    // Overshoot from an unaligned flush burst is not carried across the wrap.
    assign nxt_addr  = {1'b0, cur_addr} + (ADDR_WIDTH + 1)'(wr_len);
    assign addr_wrap = (nxt_addr >= FRAME_END);

    // Next-state and pulse outputs; every output defaults low / hold.
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        adv        = 1'b0;
        wr_trig    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig_cond) begin
                    issue   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                wr_trig = 1'b1;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (wr_done) begin
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                adv        = 1'b1;
                frame_done = addr_wrap;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request descriptor is captured at issue and held stable until the master reports completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_len  <= '0;
            wr_addr <= BASE_A;
        end else if (issue) begin
            wr_len  <= len_sel;
            wr_addr <= cur_addr;
        end
    end

    // Frame address advances by the completed burst length, wrapping to the base at the end of the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_addr <= BASE_A;
        end else if (adv) begin
            if (addr_wrap) begin
                cur_addr <= BASE_A;
            end else begin
                cur_addr <= nxt_addr[ADDR_WIDTH-1:0];
            end
        end
    end

    // Pending flush: consumed by the request it causes, or discarded in IDLE when nothing is buffered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_pend <= 1'b0;
        end else if (issue) begin
            flush_pend <= 1'b0;
        end else if ((state_q == S_IDLE) && fifo_empty) begin
            flush_pend <= 1'b0;
        end else if (flush) begin
            flush_pend <= 1'b1;
        end
    end

    // Sticky record of the master pulling a word that was not there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underflow_err <= 1'b0;
        end else if (wr_data_en && fifo_empty) begin
            underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wr_burst_feeder.sv
module tb_wr_burst_feeder;

    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int FAW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_end = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          flush = 1'b0;
    logic          wr_ready = 1'b0;
    logic          wr_data_en = 1'b0;
    logic          wr_done = 1'b0;
    logic          in_ready;
    logic          wr_trig;
    logic [7:0]    wr_len;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [FAW:0]  fifo_level;
    logic          frame_done;
    logic          underflow_err;

    int checks = 0;
    int passes = 0;
    int bursts_done = 0;
    int fd_seen = 0;
    int fd_at = -1;

    // Scoreboard: words in acceptance order, requests in expected issue order.
    logic [DW-1:0] data_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    exp_len_q[$];

    wr_burst_feeder #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .FIFO_AW     (FAW),
        .BURST_LEN   (8),
        .BASE_ADDR   (0),
        .FRAME_WORDS (1024)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_end      (init_end),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .flush         (flush),
        .wr_trig       (wr_trig),
        .wr_len        (wr_len),
        .wr_addr       (wr_addr),
        .wr_ready      (wr_ready),
        .wr_data_en    (wr_data_en),
        .wr_data       (wr_data),
        .wr_done       (wr_done),
        .fifo_level    (fifo_level),
        .frame_done    (frame_done),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        rst_n = 1'b0; init_end = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        wr_ready = 1'b0; wr_data_en = 1'b0; wr_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; init_end = 1'b1; wr_ready = 1'b1;
        data_q.delete(); exp_addr_q.delete(); exp_len_q.delete();
        bursts_done = 0; fd_seen = 0; fd_at = -1;
    endtask

    // Pushes n consecutive words, one per cycle, recording accepted words in the scoreboard.
    task automatic push_words(input int n, input logic [DW-1:0] first);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = first + 32'(i);
            @(negedge clk);
            if (in_ready) data_q.push_back(in_data);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Streams n words while modelling the write master; requests and popped data are checked against the scoreboard.
    task automatic run_traffic(input int n, input logic [DW-1:0] first, input int budget);
        int  sent;
        int  beats;
        int  cyc;
        bit  mbusy;
        sent = 0; beats = 0; cyc = 0; mbusy = 1'b0;
        while (cyc < budget && (sent < n || exp_len_q.size() != 0 || mbusy)) begin
            in_valid   = (sent < n);
            in_data    = first + 32'(sent);
            wr_data_en = mbusy && (beats > 0);
            wr_done    = mbusy && (beats == 0);
            wr_ready   = !mbusy;
            @(negedge clk);
            if (in_valid && in_ready) begin
                data_q.push_back(in_data);
                sent++;
            end
            if (wr_data_en) begin
                checks++;
                if (data_q.size() == 0) begin
                    $display("FAIL pop_data: got %08h, required no pop (scoreboard empty)", wr_data);
                end else begin
                    if (wr_data !== data_q[0])
                        $display("FAIL pop_data: got %08h, required %08h", wr_data, data_q[0]);
                    else
                        passes++;
                    void'(data_q.pop_front());
                end
                beats--;
            end
            if (wr_done) begin
                mbusy = 1'b0;
                bursts_done++;
            end
            if (frame_done) begin
                fd_seen++;
                fd_at = bursts_done;
            end
            if (wr_trig) begin
                checks++;
                if (exp_len_q.size() == 0) begin
                    $display("FAIL trig_req: got addr=%0h len=%0d, required no request", wr_addr, wr_len);
                end else begin
                    if (wr_addr !== exp_addr_q[0] || wr_len !== exp_len_q[0])
                        $display("FAIL trig_req: got addr=%0h len=%0d, required addr=%0h len=%0d",
                                 wr_addr, wr_len, exp_addr_q[0], exp_len_q[0]);
                    else
                        passes++;
                    void'(exp_addr_q.pop_front());
                    void'(exp_len_q.pop_front());
                end
                mbusy = 1'b1;
                beats = int'(wr_len);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0; wr_data_en = 1'b0; wr_done = 1'b0; wr_ready = 1'b1;
        checks++;
        if (cyc >= budget)
            $display("FAIL traffic_timeout: got %0d cycles with %0d requests outstanding, required completion", cyc, exp_len_q.size());
        else
            passes++;
        // Let ADV complete so its frame_done pulse is observed; no further request is expected.
        repeat (4) begin
            @(negedge clk);
            if (frame_done) begin
                fd_seen++;
                fd_at = bursts_done;
            end
            if (wr_trig) begin
                checks++;
                $display("FAIL tail_trig: got request addr=%0h len=%0d, required none", wr_addr, wr_len);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int trigs;
        apply_reset();
        init_end = 1'b0;
        @(negedge clk);
        checks += 7;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b, required 1", in_ready); else passes++;
        if (fifo_level !== 7'd0) $display("FAIL rst_level: got %0d, required 0", fifo_level); else passes++;
        if (wr_trig !== 1'b0) $display("FAIL rst_wr_trig: got %b, required 0", wr_trig); else passes++;
        if (wr_len !== 8'd0) $display("FAIL rst_wr_len: got %0d, required 0", wr_len); else passes++;
        if (wr_addr !== 26'd0) $display("FAIL rst_wr_addr: got %0h, required 0", wr_addr); else passes++;
        if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b, required 0", frame_done); else passes++;
        if (underflow_err !== 1'b0) $display("FAIL rst_underflow: got %b, required 0", underflow_err); else passes++;
        @(posedge clk);
        #1;
        // With init_end low a full burst must be held back.
        push_words(8, 32'h100);
        trigs = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_trig) trigs++;
        end
        checks++;
        if (trigs != 0) $display("FAIL init_gate: got %0d requests, required 0", trigs); else passes++;
        @(posedge clk);
        #1;
        init_end = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_trig !== 1'b0) $display("FAIL init_latency_early: got %b, required 0", wr_trig); else passes++;
        @(negedge clk);
        checks++;
        if (wr_trig !== 1'b1 || wr_len !== 8'd8)
            $display("FAIL init_release: got trig=%b len=%0d, required trig=1 len=8", wr_trig, wr_len);
        else passes++;
    endtask

    task automatic test_single_burst();
        apply_reset();
        push_words(8, 32'h1);
        @(negedge clk);
        checks += 2;
        if (fifo_level !== 7'd8) $display("FAIL sb_level: got %0d, required 8", fifo_level); else passes++;
        if (wr_trig !== 1'b0) $display("FAIL sb_trig_early: got %b, required 0", wr_trig); else passes++;
        @(negedge clk);
        checks++;
        if (wr_trig !== 1'b1 || wr_addr !== 26'd0 || wr_len !== 8'd8)
            $display("FAIL sb_trig: got trig=%b addr=%0h len=%0d, required trig=1 addr=0 len=8", wr_trig, wr_addr, wr_len);
        else passes++;
        @(posedge clk);
        #1;
        wr_ready = 1'b0;
        wr_data_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (wr_data !== data_q[0]) $display("FAIL sb_data: got %08h, required %08h", wr_data, data_q[0]);
            else passes++;
            void'(data_q.pop_front());
            @(posedge clk);
            #1;
        end
        wr_data_en = 1'b0;
        wr_done = 1'b1;
        @(posedge clk);
        #1;
        wr_done = 1'b0;
        wr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_level !== 7'd0) $display("FAIL sb_level_end: got %0d, required 0", fifo_level); else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame();
        apply_reset();
        for (int i = 0; i < 129; i++) begin
            exp_addr_q.push_back(26'((i * 8) % 1024));
            exp_len_q.push_back(8'd8);
        end
        run_traffic(1032, 32'h1000, 6000);
        checks += 2;
        if (fd_seen != 1) $display("FAIL frame_done_count: got %0d, required 1", fd_seen); else passes++;
        if (fd_at != 128) $display("FAIL frame_done_when: got after %0d bursts, required after 128", fd_at); else passes++;
    endtask

    task automatic test_flush();
        int trigs;
        apply_reset();
        push_words(3, 32'h301);
        trigs = 0;
        repeat (4) begin
            @(negedge clk);
            if (wr_trig) trigs++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (trigs != 0) $display("FAIL partial_no_trig: got %0d requests, required 0", trigs); else passes++;
        flush = 1'b1;
        exp_addr_q.push_back(26'd0); exp_len_q.push_back(8'd3);
        exp_addr_q.push_back(26'd3); exp_len_q.push_back(8'd8);
        @(posedge clk);
        #1;
        flush = 1'b0;
        run_traffic(8, 32'h311, 500);
        // Flush with nothing buffered is dropped and must not linger.
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        trigs = 0;
        repeat (6) begin
            @(negedge clk);
            if (wr_trig) trigs++;
        end
        @(posedge clk);
        #1;
        push_words(3, 32'h401);
        repeat (6) begin
            @(negedge clk);
            if (wr_trig) trigs++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (trigs != 0) $display("FAIL empty_flush: got %0d requests, required 0", trigs); else passes++;
    endtask

    task automatic test_backpressure();
        int acc;
        int trigs;
        apply_reset();
        wr_ready = 1'b0;
        acc = 0;
        trigs = 0;
        for (int i = 0; i < 70; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h5000 + 32'(acc);
            @(negedge clk);
            if (wr_trig) trigs++;
            if (in_ready) begin
                data_q.push_back(in_data);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks += 4;
        if (acc != 64) $display("FAIL bp_accepted: got %0d, required 64", acc); else passes++;
        if (fifo_level !== 7'd64) $display("FAIL bp_level: got %0d, required 64", fifo_level); else passes++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b, required 0", in_ready); else passes++;
        if (trigs != 0) $display("FAIL bp_held: got %0d requests, required 0", trigs); else passes++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(26'(i * 8));
            exp_len_q.push_back(8'd8);
        end
        run_traffic(6, 32'h5000 + 32'(acc), 2000);
        @(negedge clk);
        checks++;
        if (fifo_level !== 7'd6) $display("FAIL bp_leftover: got %0d, required 6", fifo_level); else passes++;
        @(posedge clk);
        #1;
        flush = 1'b1;
        exp_addr_q.push_back(26'd64); exp_len_q.push_back(8'd6);
        @(posedge clk);
        #1;
        flush = 1'b0;
        run_traffic(0, 32'h0, 500);
        @(negedge clk);
        checks += 2;
        if (fifo_level !== 7'd0) $display("FAIL bp_drained: got %0d, required 0", fifo_level); else passes++;
        if (data_q.size() != 0) $display("FAIL bp_all_words: got %0d unread, required 0", data_q.size()); else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_underflow();
        apply_reset();
        wr_data_en = 1'b1;
        @(posedge clk);
        #1;
        wr_data_en = 1'b0;
        @(negedge clk);
        checks += 2;
        if (underflow_err !== 1'b1) $display("FAIL uf_set: got %b, required 1", underflow_err); else passes++;
        if (fifo_level !== 7'd0) $display("FAIL uf_level: got %0d, required 0", fifo_level); else passes++;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (underflow_err !== 1'b1) $display("FAIL uf_sticky: got %b, required 1", underflow_err); else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_burst();
        int trigs;
        apply_reset();
        push_words(8, 32'h700);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wr_trig !== 1'b1) $display("FAIL mid_trig: got %b, required 1", wr_trig); else passes++;
        @(posedge clk);
        #1;
        wr_ready = 1'b0;
        wr_data_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wr_data_en = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_level !== 7'd5) $display("FAIL mid_level: got %0d, required 5", fifo_level); else passes++;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks += 5;
        if (fifo_level !== 7'd0) $display("FAIL mid_rst_level: got %0d, required 0", fifo_level); else passes++;
        if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b, required 1", in_ready); else passes++;
        if (wr_len !== 8'd0) $display("FAIL mid_rst_wr_len: got %0d, required 0", wr_len); else passes++;
        if (wr_addr !== 26'd0) $display("FAIL mid_rst_wr_addr: got %0h, required 0", wr_addr); else passes++;
        if (wr_trig !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL mid_rst_pulses: got trig=%b frame_done=%b, required 0 0", wr_trig, frame_done);
        else passes++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_ready = 1'b1;
        data_q.delete();
        push_words(7, 32'h800);
        trigs = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_trig) trigs++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (trigs != 0) $display("FAIL mid_no_stale: got %0d requests, required 0", trigs); else passes++;
        exp_addr_q.push_back(26'd0); exp_len_q.push_back(8'd8);
        run_traffic(1, 32'h807, 300);
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_frame();
        test_flush();
        test_backpressure();
        test_underflow();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
